// File: rtl/l1i_cache.sv
`default_nettype none
// ============================================================================
//  l1i_cache : direct-mapped L1 instruction cache (16 lines x 4 words) with a
//              zero-latency hit path and a word-serial MMU refill engine.
//  Revision  : 1.0
// ============================================================================
module l1i_cache (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic        invalidate,
   output logic        cpu_ready,
   output logic [31:0] cpu_data,
   output logic        mem_read_enable,
   output logic [31:0] mem_address,
   output logic [1:0]  mem_data_width,
   input  logic        mem_ready,
   input  logic [31:0] mem_data_out,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam logic [1:0]  MMU_WIDTH_WORD = 2'd2;
   localparam logic [15:0] CNT_MAX        = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_REFILL = 2'b01
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] valid_q, valid_d;
   logic [23:0] tag_q, tag_d;
   logic [3:0]  index_q, index_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   logic [31:0] data_ram [0:63];
   logic [23:0] tag_ram  [0:15];
   logic        data_we;
   logic        tag_we;

   logic [3:0]  lk_index;
   logic [23:0] lk_tag;
   logic [1:0]  lk_offset;
   logic        lookup_hit;
   logic        unused_addr_bits;

   assign lk_index         = cpu_addr[7:4];
   assign lk_tag           = cpu_addr[31:8];
   assign lk_offset        = cpu_addr[3:2];
   assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

   assign lookup_hit = (state_q == S_IDLE) && cpu_req && !invalidate &&
                       valid_q[lk_index] && (tag_ram[lk_index] == lk_tag);

   assign mem_data_width = MMU_WIDTH_WORD;
   assign hit_count      = hit_cnt_q;
   assign miss_count     = miss_cnt_q;

   always_comb begin
      state_d         = state_q;
      valid_d         = valid_q;
      tag_d           = tag_q;
      index_d         = index_q;
      cnt_d           = cnt_q;
      pend_d          = pend_q;
      hit_cnt_d       = hit_cnt_q;
      miss_cnt_d      = miss_cnt_q;
      data_we         = 1'b0;
      tag_we          = 1'b0;
      cpu_ready       = 1'b0;
      cpu_data        = 32'd0;
      mem_read_enable = 1'b0;
      mem_address     = 32'd0;

      case (state_q)
         S_IDLE: begin
            // invalidate outranks a simultaneous fetch: no lookup, no refill
            if (invalidate) begin
               valid_d = 16'd0;
            end else if (cpu_req) begin
               if (lookup_hit) begin
                  cpu_ready = 1'b1;
                  cpu_data  = data_ram[{lk_index, lk_offset}];
                  if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 16'd1;
               end else begin
                  tag_d   = lk_tag;
                  index_d = lk_index;
                  cnt_d   = 2'd0;
                  pend_d  = 1'b0;
                  state_d = S_REFILL;
                  if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + 16'd1;
               end
            end
         end

         S_REFILL: begin
            mem_read_enable = 1'b1;
            mem_address     = {tag_q, index_q, cnt_q, 2'b00};
            if (invalidate) begin
               valid_d = 16'd0;
               pend_d  = 1'b1;
            end
            if (mem_ready) begin
               data_we = 1'b1;
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  tag_we = 1'b1;
                  // a fence.i seen at any point of the refill leaves the line invalid
                  if (!pend_q && !invalidate) valid_d[index_q] = 1'b1;
                  pend_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
            pend_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         valid_q    <= 16'd0;
         tag_q      <= 24'd0;
         index_q    <= 4'd0;
         cnt_q      <= 2'd0;
         pend_q     <= 1'b0;
         hit_cnt_q  <= 16'd0;
         miss_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         index_q    <= index_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) data_ram[{index_q, cnt_q}] <= mem_data_out;
      if (tag_we)  tag_ram[index_q]           <= tag_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_l1i_cache.sv
`default_nettype none
// ============================================================================
//  tb_l1i_cache : directed + randomized bench; a line-residency model with a
//                 fixed backing-memory function predicts every cycle.
//  Revision     : 1.0
// ============================================================================
module tb_l1i_cache;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = 32'd0;
   logic        invalidate = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_data_out = 32'd0;
   logic        cpu_ready;
   logic [31:0] cpu_data;
   logic        mem_read_enable;
   logic [31:0] mem_address;
   logic [1:0]  mem_data_width;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int n_vec = 0;
   int n_err = 0;

   // model: which memory line each index holds, plus refill progress
   bit          m_busy = 1'b0;
   bit [27:0]   m_line = 28'd0;
   int          m_word = 0;
   bit          m_pend = 1'b0;
   bit [15:0]   m_valid = 16'd0;
   bit [27:0]   m_res [16];
   int          m_hits = 0;
   int          m_misses = 0;
   logic [31:0] ea;
   logic        e_hit;

   l1i_cache dut (
      .clk             (clk),
      .reset           (reset),
      .cpu_req         (cpu_req),
      .cpu_addr        (cpu_addr),
      .invalidate      (invalidate),
      .cpu_ready       (cpu_ready),
      .cpu_data        (cpu_data),
      .mem_read_enable (mem_read_enable),
      .mem_address     (mem_address),
      .mem_data_width  (mem_data_width),
      .mem_ready       (mem_ready),
      .mem_data_out    (mem_data_out),
      .hit_count       (hit_count),
      .miss_count      (miss_count)
   );

   always #5 clk = ~clk;

   // backing memory contents; words 0x0..0xC hold 0xA0..0xA3
   function automatic logic [31:0] memfn(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w < 32'h10) return 32'hA0 + 32'(w[3:2]);
      return (w * 32'h9E3779B1) ^ 32'hC0FFEE00;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a       = $urandom;
      a[31:8] = 24'($urandom_range(0, 2));
      a[7:6]  = 2'b00;
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // per-cycle compare against the model, then advance the model past the edge
   initial forever begin
      @(negedge clk);
      if (reset) begin
         m_busy = 1'b0; m_word = 0; m_pend = 1'b0; m_valid = 16'd0;
         m_hits = 0; m_misses = 0;
         chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
         chk("rst_cpu_data", cpu_data, 32'd0);
         chk("rst_mem_read_enable", 32'(mem_read_enable), 32'd0);
         chk("rst_mem_address", mem_address, 32'd0);
         chk("rst_hit_count", 32'(hit_count), 32'd0);
         chk("rst_miss_count", 32'(miss_count), 32'd0);
      end else begin
         ea    = {cpu_addr[31:2], 2'b00};
         e_hit = !m_busy && cpu_req && !invalidate && m_valid[ea[7:4]] &&
                 (m_res[ea[7:4]] == ea[31:4]);
         chk("cpu_ready", 32'(cpu_ready), 32'(e_hit));
         if (e_hit) chk("cpu_data", cpu_data, memfn(ea));
         chk("mem_read_enable", 32'(mem_read_enable), 32'(m_busy));
         if (m_busy) chk("mem_address", mem_address, {m_line, m_word[1:0], 2'b00});
         chk("hit_count", 32'(hit_count), 32'(m_hits));
         chk("miss_count", 32'(miss_count), 32'(m_misses));
         if (!m_busy) begin
            if (invalidate) m_valid = 16'd0;
            else if (cpu_req) begin
               if (e_hit) m_hits = sat_inc(m_hits);
               else begin
                  m_busy = 1'b1; m_line = ea[31:4]; m_word = 0; m_pend = 1'b0;
                  m_misses = sat_inc(m_misses);
               end
            end
         end else begin
            if (invalidate) begin m_valid = 16'd0; m_pend = 1'b1; end
            if (mem_ready) begin
               if (m_word == 3) begin
                  m_busy = 1'b0;
                  m_res[m_line[3:0]] = m_line;
                  m_valid[m_line[3:0]] = !m_pend;
                  m_pend = 1'b0;
               end else m_word++;
            end
         end
      end
   end

   // one clock of stimulus; returns just after the sampling edge
   task automatic tick(input logic req, input logic [31:0] addr, input logic inv, input logic rdy);
      @(posedge clk); #1;
      cpu_req      = req;
      cpu_addr     = addr;
      invalidate   = inv;
      mem_ready    = rdy;
      mem_data_out = m_busy ? memfn({m_line, m_word[1:0], 2'b00}) : $urandom;
      @(negedge clk); #1;
   endtask

   task automatic refill_rest(input int delay);
      for (int w = 0; w < 4; w++) begin
         repeat (delay) tick(1'b0, rand_addr(), 1'b0, 1'b0);
         tick(1'b0, rand_addr(), 1'b0, 1'b1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      tick(1'b0, 32'd0, 1'b0, 1'b0);
      chk("post_rst_miss_count", 32'(miss_count), 32'd0);
      chk("mem_data_width", 32'(mem_data_width), 32'd2);

      // cold fetch of 0x0 with a 2-cycle MMU delay per word
      tick(1'b1, 32'h0, 1'b0, 1'b0);
      chk("cold_miss_ready", 32'(cpu_ready), 32'd0);
      for (int w = 0; w < 4; w++) begin
         tick(1'b1, 32'h0, 1'b0, 1'b0);
         tick(1'b1, 32'h0, 1'b0, 1'b0);
         tick(1'b1, 32'h0, 1'b0, 1'b1);
         chk("cold_refill_addr", mem_address, 32'(w * 4));
         chk("cold_refill_mre", 32'(mem_read_enable), 32'd1);
      end
      tick(1'b1, 32'h0, 1'b0, 1'b0);
      chk("cold_first_idle_ready", 32'(cpu_ready), 32'd1);
      chk("cold_first_idle_data", cpu_data, 32'hA0);
      chk("cold_miss_count", 32'(miss_count), 32'd1);

      // warm hit on word 2
      tick(1'b1, 32'h8, 1'b0, 1'b0);
      chk("warm_ready", 32'(cpu_ready), 32'd1);
      chk("warm_data", cpu_data, 32'hA2);
      chk("warm_mre", 32'(mem_read_enable), 32'd0);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      chk("warm_hit_count", 32'(hit_count), 32'd2);

      // invalidate together with a request: no hit, no refill
      tick(1'b1, 32'h8, 1'b1, 1'b0);
      chk("inv_req_ready", 32'(cpu_ready), 32'd0);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      chk("inv_req_no_refill", 32'(mem_read_enable), 32'd0);
      chk("inv_req_miss_count", 32'(miss_count), 32'd1);

      // conflict pair on index 0
      tick(1'b1, 32'h100, 1'b0, 1'b0);
      refill_rest(1);
      tick(1'b1, 32'h100, 1'b0, 1'b0);
      chk("conflict_a_ready", 32'(cpu_ready), 32'd1);
      tick(1'b1, 32'h0, 1'b0, 1'b0);
      chk("conflict_b_miss", 32'(cpu_ready), 32'd0);
      refill_rest(0);
      tick(1'b1, 32'h0, 1'b0, 1'b0);
      chk("conflict_b_data", cpu_data, 32'hA0);
      chk("conflict_miss_count", 32'(miss_count), 32'd3);

      // invalidate while word 1 of 0x40 is returning
      tick(1'b1, 32'h40, 1'b0, 1'b0);
      tick(1'b0, rand_addr(), 1'b0, 1'b1);
      tick(1'b0, rand_addr(), 1'b1, 1'b1);
      tick(1'b0, rand_addr(), 1'b0, 1'b1);
      tick(1'b0, rand_addr(), 1'b0, 1'b1);
      tick(1'b1, 32'h40, 1'b0, 1'b0);
      chk("inv_refill_remiss", 32'(cpu_ready), 32'd0);
      refill_rest(0);
      tick(1'b1, 32'h40, 1'b0, 1'b0);
      chk("inv_refill_then_hit", 32'(cpu_ready), 32'd1);
      chk("inv_refill_miss_count", 32'(miss_count), 32'd5);

      for (int i = 0; i < 3000; i++)
         tick(($urandom % 5) != 0, rand_addr(), ($urandom % 40) == 0, ($urandom % 3) == 0);

      for (int k = 0; k < 16 && m_busy; k++) tick(1'b0, rand_addr(), 1'b0, 1'b1);
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      tick(1'b1, 32'h0, 1'b0, 1'b0);
      refill_rest(0);
      tick(1'b1, 32'h0, 1'b0, 1'b0);
      chk("pre_reset_line_hit", 32'(cpu_ready), 32'd1);

      // reset while the 0x80 refill waits on word 2
      tick(1'b1, 32'h80, 1'b0, 1'b0);
      tick(1'b0, rand_addr(), 1'b0, 1'b1);
      tick(1'b0, rand_addr(), 1'b0, 1'b1);
      tick(1'b0, rand_addr(), 1'b0, 1'b0);
      chk("await_w2_mre", 32'(mem_read_enable), 32'd1);
      chk("await_w2_addr", mem_address, 32'h88);
      @(posedge clk); #2;
      cpu_req = 1'b0; invalidate = 1'b0; mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("async_rst_mre", 32'(mem_read_enable), 32'd0);
      chk("async_rst_hit_count", 32'(hit_count), 32'd0);
      chk("async_rst_miss_count", 32'(miss_count), 32'd0);
      @(negedge clk);
      @(posedge clk); #2 reset = 1'b0;
      tick(1'b1, 32'h0, 1'b0, 1'b0);
      chk("post_rst_prior_line_miss", 32'(cpu_ready), 32'd0);
      refill_rest(0);

      // saturation of the hit counter
      for (int i = 0; i < 32'h10002; i++) tick(1'b1, 32'h0, 1'b0, 1'b0);
      chk("sat_hit_count", 32'(hit_count), 32'hFFFF);
      chk("sat_miss_count", 32'(miss_count), 32'd1);
      chk("sat_still_hits", 32'(cpu_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l1i_cache.md
L1I_CACHE -- requirements
Module: l1i_cache

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 cpu_req  in  1  fetch request valid.
REQ-005 cpu_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 invalidate  in  1  clear all valid bits (fence.i).
REQ-007 cpu_ready  out  1  cpu_data valid this cycle.
REQ-008 cpu_data  out  32  fetched instruction word.
REQ-009 mem_read_enable  out  1  refill read request to MMU.
REQ-010 mem_address  out  32  refill word address, word-aligned.
REQ-011 mem_data_width  out  2  constant MMU_WIDTH_WORD.
REQ-012 mem_ready  in  1  MMU read complete; mem_data_out valid this cycle.
REQ-013 mem_data_out  in  32  MMU read data.
REQ-014 hit_count, miss_count  out  16 each  saturating performance counters.

Function
REQ-015 Organisation SHALL be direct-mapped: 16 lines x 4 words; offset = addr[3:2], index = addr[7:4], tag = addr[31:8] (24 bits); one valid bit per line.
REQ-016 States SHALL be IDLE and REFILL; any unused encoding SHALL return to IDLE.
REQ-017 In IDLE, a hit (cpu_req=1, valid[index]=1, tag match, invalidate=0) SHALL assert cpu_ready combinationally in the same cycle, with cpu_data = the addressed word; zero-cycle hit latency.
REQ-018 In IDLE, a miss (cpu_req=1, invalidate=0, no hit) SHALL hold cpu_ready=0, latch tag/index, clear the word counter, and enter REFILL at the next edge.
REQ-019 In REFILL, the block SHALL drive mem_read_enable=1 with mem_address = {tag, index, counter, 2'b00}, words 0..3 in order, holding the address stable until mem_ready=1.
REQ-020 On each mem_ready=1 in REFILL, the block SHALL write mem_data_out into word[counter] of the latched line and increment counter (2-bit); the next word's request follows on the next cycle with no gap.
REQ-021 On mem_ready for word 3, the block SHALL write the tag, set valid (unless REQ-024 applies), and return to IDLE; the pending fetch then hits in the first IDLE cycle.
REQ-022 cpu_ready SHALL be 0 throughout REFILL; cpu_addr changes during REFILL SHALL NOT alter the refill; the address present in the first IDLE cycle is looked up afresh.
REQ-023 invalidate in IDLE SHALL clear all 16 valid bits at the next edge; when invalidate and cpu_req are both high, invalidate wins, with cpu_ready=0 and no refill started.
REQ-024 invalidate during REFILL SHALL clear all valid bits at the next edge and set a pending flag; the refill completes, the refilled line SHALL stay invalid, and the flag clears on return to IDLE.
REQ-025 mem_read_enable SHALL be 0 in IDLE; the block never writes memory.
REQ-026 hit_count SHALL increment once per REQ-017 hit cycle and miss_count once per REQ-018 miss; both saturate at 16'hFFFF.

Reset
REQ-027 Reset SHALL take effect immediately, including mid-refill: state=IDLE, all valid bits=0, counter=0, pending flag=0, mem_read_enable=0, cpu_ready=0, cpu_data=0, mem_address=0, hit_count=0, miss_count=0; data/tag arrays need no reset.

Verification
REQ-028 Cold fetch 0x00000000, MMU returns 0xA0,0xA1,0xA2,0xA3 each with 2-cycle mem_ready delay -> reads at 0x0,0x4,0x8,0xC; cpu_ready=1, cpu_data=0xA0 in first IDLE cycle; miss_count=1.
REQ-029 Fetch 0x00000008 after that -> cpu_ready=1 same cycle, cpu_data=0xA2, no mem_read_enable; hit_count increments by 1.
REQ-030 Fetch 0x00000100 (index 0, new tag) then 0x00000000 -> both miss and refill; miss_count increases by 2.
REQ-031 invalidate asserted during the word-1 refill of 0x40 -> refill completes; a later 0x40 fetch misses again.
REQ-032 reset pulsed while REFILL awaits word 2 -> mem_read_enable drops in the same cycle, counters=0, prior lines miss.
REQ-033 0x10000 consecutive hits -> hit_count holds at 0xFFFF.
